bram_pattern_player: RTL and testbench

Pattern playback engine for the LED, backed by one 256x16 block RAM (SB_RAM256x16 mapping).
- Host side loads 16-bit pattern words over a valid/ready write port while idle.
- Player side reads the words back from the RAM and shifts them out MSB-first on `led`, one bit per tick period.
- It is the reader/consumer for the block RAM in the top level and replaces the hard-wired blink pattern constant.

---
 rtl/bram_pattern_player.sv | 137 +++++++++++++
 tb/tb_bram_pattern_player.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bram_pattern_player.sv
// LED pattern playback engine: host loads 16-bit words into a 256x16 block RAM,
// the player streams them MSB-first on led, one bit per TICK_DIV clock cycles.
module bram_pattern_player #(
    parameter int TICK_DIV = 2097152,
    parameter int CNT_W    = 26
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        start,
    input  logic        stop,
    input  logic [7:0]  last_addr,
    output logic        busy,
    output logic        led,
    output logic        wrap
);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  tick;
    logic [3:0]        bitcnt;
    logic [7:0]        rd_addr;
    logic [7:0]        end_addr;
    logic [15:0]       shreg;
    logic [15:0]       rd_data;
    logic [15:0]       mem [0:255];

    logic tick_done;
    assign tick_done = (tick == TICK_LAST);

    // Block RAM: no reset so it maps onto the hard RAM and keeps its contents
    // across a reset of the player.
    always_ff @(posedge CLK) begin
        if (wr_valid && wr_ready) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start && !stop) next_state = FETCH;
            FETCH: next_state = stop ? IDLE : LOAD;
            LOAD:  next_state = stop ? IDLE : PLAY;
            PLAY: begin
                if (stop) begin
                    next_state = IDLE;
                end else if (tick_done && bitcnt == 4'd15) begin
                    next_state = FETCH;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath; led holds bit 0 through FETCH/LOAD so the last bit runs two
    // cycles longer than the others.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            led      <= 1'b0;
            wrap     <= 1'b0;
            wr_ready <= 1'b0;
            tick     <= '0;
            bitcnt   <= '0;
            rd_addr  <= '0;
            end_addr <= '0;
            shreg    <= '0;
        end else begin
            wrap     <= 1'b0;
            wr_ready <= (next_state == IDLE);
            if (state != IDLE && stop) begin
                led     <= 1'b0;
                tick    <= '0;
                bitcnt  <= '0;
                rd_addr <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        led <= 1'b0;
                        if (start) begin
                            end_addr <= last_addr;
                            rd_addr  <= '0;
                        end
                    end
                    FETCH: begin
                    end
                    LOAD: begin
                        shreg  <= rd_data;
                        led    <= rd_data[15];
                        bitcnt <= '0;
                        tick   <= '0;
                    end
                    PLAY: begin
                        if (tick_done) begin
                            tick <= '0;
                            if (bitcnt != 4'd15) begin
                                shreg  <= shreg << 1;
                                led    <= shreg[14];
                                bitcnt <= bitcnt + 4'd1;
                            end else if (rd_addr == end_addr) begin
                                rd_addr <= '0;
                                wrap    <= 1'b1;
                            end else begin
                                rd_addr <= rd_addr + 8'd1;
                            end
                        end else begin
                            tick <= tick + CNT_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bram_pattern_player.sv
// Self-checking bench for bram_pattern_player: directed and random playback
// compared against an arithmetic model of the led/wrap timeline.
module tb_bram_pattern_player;

    localparam int T = 4;
    localparam int P = 16 * T + 2;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  last_addr = '0;
    logic        busy;
    logic        led;
    logic        wrap;

    int passed = 0;
    int total  = 0;
    logic [15:0] ref_mem [0:255];

    bram_pattern_player #(.TICK_DIV(T), .CNT_W(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .last_addr(last_addr),
        .busy(busy), .led(led), .wrap(wrap)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
    endtask

    // Edge n after the start edge: two setup edges, then each word occupies
    // P edges; bits 15..1 last T each, bit 0 the remainder.
    function automatic void model(input int n, input int nw, output logic e_led, output logic e_wrap);
        int m, widx, r, bitpos;
        e_led  = 1'b0;
        e_wrap = 1'b0;
        if (n >= 2) begin
            m      = n - 2;
            widx   = (m / P) % nw;
            r      = m % P;
            bitpos = (r < 15 * T) ? 15 - r / T : 0;
            e_led  = ref_mem[widx][bitpos];
            e_wrap = (r == 16 * T) && (widx == nw - 1);
        end
    endfunction

    task automatic write_word(input logic [7:0] a, input logic [15:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        check("wr_ready_idle", wr_ready, 1'b1);
        step();
        wr_valid = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic play(input logic [7:0] last, input int ncycles, input int start_at, input bit blocked);
        logic e_led, e_wrap;
        start     = 1'b1;
        last_addr = last;
        step();
        start     = 1'b0;
        last_addr = 8'($urandom);
        if (blocked) begin
            wr_valid = 1'b1;
            wr_addr  = 8'd0;
            wr_data  = 16'h1234;
        end
        for (int n = 1; n <= ncycles; n++) begin
            start = (n == start_at);
            step();
            start = 1'b0;
            model(n, int'(last) + 1, e_led, e_wrap);
            check("led", led, e_led);
            check("wrap", wrap, e_wrap);
            check("busy", busy, 1'b1);
            if (blocked) check("wr_ready_busy", wr_ready, 1'b0);
        end
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_led", led, 1'b0);
        check("stop_busy", busy, 1'b0);
        check("stop_wrap", wrap, 1'b0);
        check("stop_wr_ready", wr_ready, 1'b1);
    endtask

    initial begin
        int nw, nc;

        // Reset held for three edges
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_led", led, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_wrap", wrap, 1'b0);
            check("rst_wr_ready", wr_ready, 1'b0);
        end
        RST_N = 1'b1;
        check("rel_wr_ready_pre", wr_ready, 1'b0);
        step();
        check("rel_wr_ready", wr_ready, 1'b1);
        check("rel_busy", busy, 1'b0);

        // Single word A5F0 looping
        write_word(8'd0, 16'hA5F0);
        play(8'd0, 2 * P + 10, 0, 1'b0);
        do_stop();

        // Three words with wrap after the last
        write_word(8'd0, 16'hFFFF);
        write_word(8'd1, 16'h0000);
        write_word(8'd2, 16'h8001);
        play(8'd2, 2 * 3 * P + 5, 0, 1'b0);
        do_stop();

        // Writes are refused while busy, accepted once idle again
        play(8'd2, 3 * P + 12, 0, 1'b1);
        do_stop();
        step();
        wr_valid = 1'b0;
        ref_mem[0] = 16'h1234;
        check("post_write_wr_ready", wr_ready, 1'b1);
        play(8'd0, P + 20, 0, 1'b0);
        do_stop();

        // start+stop together in idle stays idle
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_busy", busy, 1'b0);
        check("ss_wr_ready", wr_ready, 1'b1);
        check("ss_led", led, 1'b0);
        // start during play is ignored; stop mid-word
        write_word(8'd1, 16'h5A3C);
        play(8'd1, P + 30, 40, 1'b0);
        do_stop();

        // Asynchronous reset mid-play, then replay from retained RAM
        write_word(8'd0, 16'hFFFF);
        write_word(8'd1, 16'h0000);
        play(8'd2, 10, 0, 1'b0);
        #2;
        RST_N = 1'b0;
        #1;
        check("arst_led", led, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_wrap", wrap, 1'b0);
        check("arst_wr_ready", wr_ready, 1'b0);
        step();
        RST_N = 1'b1;
        step();
        check("arst_rel_wr_ready", wr_ready, 1'b1);
        play(8'd2, 3 * P + 10, 0, 1'b0);
        do_stop();

        // Random words, lengths and stray start pulses
        for (int it = 0; it < 5; it++) begin
            nw = $urandom_range(1, 4);
            for (int a = 0; a < nw; a++) begin
                write_word(8'(a), 16'($urandom));
            end
            nc = $urandom_range(50, nw * P * 2);
            play(8'(nw - 1), nc, $urandom_range(3, nc), 1'b0);
            do_stop();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
